// File: rtl/sign_mag_adder.sv
// rtl/sign_mag_adder.sv - combinational 8-bit sign-magnitude adder, 9-bit sign-magnitude result
//
// Ports:
//   a   in  [7:0]  operand A, bit 7 sign, bits 6:0 magnitude
//   b   in  [7:0]  operand B, same format
//   sum out [8:0]  bit 8 sign, bits 7:0 magnitude of A+B
module sign_mag_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [8:0] sum
);

  logic [7:0] a_mag;
  logic [7:0] b_mag;

  assign a_mag = {1'b0, a[6:0]};
  assign b_mag = {1'b0, b[6:0]};

  always_comb begin
    sum = 9'h000;
    if (a[7] == b[7]) begin
      sum = {a[7], a_mag + b_mag};
    end else if (a_mag > b_mag) begin
      sum = {a[7], a_mag - b_mag};
    end else begin
      // Equal magnitudes fall here too: zero magnitude carrying B's sign.
      sum = {b[7], b_mag - a_mag};
    end
  end

endmodule

// File: rtl/sign_mag_add_arbiter.sv
// rtl/sign_mag_add_arbiter.sv - two-requester arbiter sharing one sign-magnitude adder
//
// Optional build macro: SM_NEG_ZERO_CLAMP_EN (defined: a captured -0 becomes +0).
//
// Parameters:
//   ADD_LAT    cycles from grant to result capture (1..4)
//   PRIO_MODE  0 = round-robin, 1 = requester 0 always wins
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   req0/a0/b0/gnt0    requester 0 request, operands, one-cycle grant pulse
//   req1/a1/b1/gnt1    requester 1 request, operands, one-cycle grant pulse
//   res_valid          result available, held until res_ack
//   res_id             requester owning res_sum
//   res_sum            bit 8 sign, bits 7:0 magnitude
//   res_ack            consumer accepts the result
//   busy               high whenever the FSM is not idle
module sign_mag_add_arbiter #(
  parameter int ADD_LAT   = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt1,
  output logic       res_valid,
  output logic       res_id,
  output logic [8:0] res_sum,
  input  logic       res_ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       last_srv;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       win;
  logic [8:0] add_sum;
  logic [8:0] cap_sum;

  // The adder only ever sees the latched operands, so requesters may
  // change their inputs freely once granted.
  sign_mag_adder u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

`ifdef SM_NEG_ZERO_CLAMP_EN
  assign cap_sum = {add_sum[8] & (|add_sum[7:0]), add_sum[7:0]};
`else
  assign cap_sum = add_sum;
`endif

  // Winner selection; only meaningful in IDLE with at least one request.
  always_comb begin
    win = 1'b0;
    if (PRIO_MODE == 1) begin
      win = ~req0;
    end else if (req0 && req1) begin
      win = ~last_srv;
    end else begin
      win = ~req0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      last_srv  <= 1'b1;
      op_a      <= 8'h00;
      op_b      <= 8'h00;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_sum   <= 9'h000;
      busy      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            op_a   <= win ? a1 : a0;
            op_b   <= win ? b1 : b0;
            gnt0   <= ~win;
            gnt1   <= win;
            res_id <= win;
            cnt    <= 3'(ADD_LAT);
            busy   <= 1'b1;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            res_sum   <= cap_sum;
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            last_srv  <= res_id;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_mag_add_arbiter.sv
// tb/tb_sign_mag_add_arbiter.sv - directed self-checking bench for sign_mag_add_arbiter
module tb_sign_mag_add_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, res_ack = 1'b0;
  logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;

  logic       gnt0, gnt1, res_valid, res_id, busy;
  logic [8:0] res_sum;
  logic       p_gnt0, p_gnt1, p_res_valid, p_res_id, p_busy;
  logic [8:0] p_res_sum;

  logic       l_req0 = 1'b0, l_ack = 1'b0;
  logic [7:0] l_a0 = 8'h00, l_b0 = 8'h00;
  logic       l_gnt0, l_gnt1, l_res_valid, l_res_id, l_busy;
  logic [8:0] l_res_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sign_mag_add_arbiter #(.ADD_LAT(1), .PRIO_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
    .res_ack(res_ack), .busy(busy)
  );

  sign_mag_add_arbiter #(.ADD_LAT(1), .PRIO_MODE(1)) dut_prio (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(p_gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(p_gnt1),
    .res_valid(p_res_valid), .res_id(p_res_id), .res_sum(p_res_sum),
    .res_ack(res_ack), .busy(p_busy)
  );

  sign_mag_add_arbiter #(.ADD_LAT(3), .PRIO_MODE(0)) dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .req0(l_req0), .a0(l_a0), .b0(l_b0), .gnt0(l_gnt0),
    .req1(1'b0), .a1(8'h00), .b1(8'h00), .gnt1(l_gnt1),
    .res_valid(l_res_valid), .res_id(l_res_id), .res_sum(l_res_sum),
    .res_ack(l_ack), .busy(l_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] neg_zero_exp;
`ifdef SM_NEG_ZERO_CLAMP_EN
    neg_zero_exp = 9'h000;
`else
    neg_zero_exp = 9'h100;
`endif

    // Reset state
    tick; tick;
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_id", 32'(res_id), 0);
    chk("rst_sum", 32'(res_sum), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;

    // 5 + (-3) = +2 on requester 0
    req0 = 1'b1; a0 = 8'h05; b0 = 8'h83;
    tick;
    chk("t1_gnt0", 32'(gnt0), 1);
    chk("t1_gnt1", 32'(gnt1), 0);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_valid_early", 32'(res_valid), 0);
    req0 = 1'b0;
    tick;
    chk("t1_gnt0_clear", 32'(gnt0), 0);
    chk("t1_valid", 32'(res_valid), 1);
    chk("t1_sum", 32'(res_sum), 32'h002);
    chk("t1_id", 32'(res_id), 0);
    tick;
    chk("t1_hold_valid", 32'(res_valid), 1);
    chk("t1_hold_sum", 32'(res_sum), 32'h002);
    res_ack = 1'b1;
    tick;
    res_ack = 1'b0;
    chk("t1_ack_valid", 32'(res_valid), 0);
    chk("t1_ack_busy", 32'(busy), 0);
    chk("t1_ack_sum_kept", 32'(res_sum), 32'h002);

    // Requester 1 alone, held high for two operations
    req1 = 1'b1; a1 = 8'h7F; b1 = 8'h7F;
    tick;
    chk("t2_gnt1", 32'(gnt1), 1);
    chk("t2_gnt0", 32'(gnt0), 0);
    a1 = 8'h85; b1 = 8'h85;
    tick;
    chk("t2_sum_a", 32'(res_sum), 32'h0FE);
    chk("t2_id_a", 32'(res_id), 1);
    res_ack = 1'b1;
    tick;
    res_ack = 1'b0;
    tick;
    chk("t2_gnt1_b", 32'(gnt1), 1);
    req1 = 1'b0;
    tick;
    chk("t2_valid_b", 32'(res_valid), 1);
    chk("t2_sum_b", 32'(res_sum), 32'h10A);
    chk("t2_id_b", 32'(res_id), 1);
    res_ack = 1'b1;
    tick;
    res_ack = 1'b0;

    // Both held high: round-robin alternates from 0, fixed priority always 0
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
    req1 = 1'b1; a1 = 8'h10; b1 = 8'h20;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 1 : 0);
      chk("rr_gnt1", 32'(gnt1), (i % 2 == 0) ? 0 : 1);
      chk("prio_gnt0", 32'(p_gnt0), 1);
      chk("prio_gnt1", 32'(p_gnt1), 0);
      tick;
      chk("rr_id", 32'(res_id), i % 2);
      chk("rr_sum", 32'(res_sum), (i % 2 == 0) ? 32'h003 : 32'h030);
      chk("prio_id", 32'(p_res_id), 0);
      res_ack = 1'b1;
      tick;
      res_ack = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Equal magnitudes, opposite signs: -0 unless clamped
    req0 = 1'b1; a0 = 8'h05; b0 = 8'h85;
    tick;
    req0 = 1'b0;
    tick;
    chk("negz_sum", 32'(res_sum), 32'(neg_zero_exp));
    res_ack = 1'b1;
    tick;
    res_ack = 1'b0;

    // ADD_LAT=3, operands changed right after the grant
    l_req0 = 1'b1; l_a0 = 8'h10; l_b0 = 8'h05;
    tick;
    chk("lat3_gnt0", 32'(l_gnt0), 1);
    l_req0 = 1'b0; l_a0 = 8'h01; l_b0 = 8'h81;
    tick;
    chk("lat3_valid_e1", 32'(l_res_valid), 0);
    tick;
    chk("lat3_valid_e2", 32'(l_res_valid), 0);
    tick;
    chk("lat3_valid_e3", 32'(l_res_valid), 1);
    chk("lat3_sum", 32'(l_res_sum), 32'h015);
    l_ack = 1'b1;
    tick;
    l_ack = 1'b0;
    chk("lat3_ack", 32'(l_res_valid), 0);

    // Reset while computing discards the operation
    req0 = 1'b1; a0 = 8'h05; b0 = 8'h03;
    l_req0 = 1'b1; l_a0 = 8'h02; l_b0 = 8'h02;
    tick;
    chk("mr_gnt_l3", 32'(l_gnt0), 1);
    req0 = 1'b0; l_req0 = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mr_valid", 32'(res_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_sum", 32'(res_sum), 0);
    chk("mr_gnt0", 32'(gnt0), 0);
    chk("mr_l3_busy", 32'(l_busy), 0);
    chk("mr_l3_sum", 32'(l_res_sum), 0);
    req0 = 1'b1; req1 = 1'b1;
    tick;
    chk("mr_first_gnt0", 32'(gnt0), 1);
    chk("mr_first_gnt1", 32'(gnt1), 0);
    chk("mr_l3_no_valid", 32'(l_res_valid), 0);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    chk("mr_after_id", 32'(res_id), 0);
    chk("mr_after_sum", 32'(res_sum), 32'h008);
    chk("mr_l3_still_idle", 32'(l_res_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_mag_add_arbiter.md
Name: sign_mag_add_arbiter

Overview:
- Shares one 8-bit sign-magnitude adder datapath (sign_mag_adder: 8-bit operands, 9-bit result) between two requesters.
- Arbitrates requests, latches the winner's operands, and waits a programmable number of cycles for the datapath to settle.
- Returns a registered, requester-tagged 9-bit result under a valid/ack handshake.
- Sits between the lab's operand-producing blocks and the shared combinational adder; the adder is instantiated inside this block.

Parameters:
- ADD_LAT, 1, cycles from grant to result capture; legal range 1..4; modelled settle time of the adder.
- PRIO_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 always wins.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- req0  input  1  requester 0 wants an addition; a0/b0 valid while high.
- a0  input  8  requester 0 operand A; bit 7 = sign, bits 6:0 = magnitude.
- b0  input  8  requester 0 operand B; same format as a0.
- gnt0  output  1  one-cycle pulse: a0/b0 latched.
- req1  input  1  requester 1 request.
- a1  input  8  requester 1 operand A.
- b1  input  8  requester 1 operand B.
- gnt1  output  1  one-cycle pulse for requester 1.
- res_valid  output  1  result available.
- res_id  output  1  requester that owns res_sum (0 or 1).
- res_sum  output  9  bit 8 = sign, bits 7:0 = magnitude of A+B.
- res_ack  input  1  consumer accepts the result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: rst_n sampled low at a rising edge forces IDLE.
  - gnt0 = gnt1 = res_valid = res_id = busy = 0; res_sum = 9'h000.
  - Wait counter = 0; last-served pointer = 1, so requester 0 wins first.
  - Reset is legal mid-operation; the in-flight result is discarded and no res_valid is produced.
- FSM has three states: IDLE, COMPUTE, RESP.
- IDLE:
  - At an edge where req0 or req1 is high, select the winner.
  - PRIO_MODE=0: a sole requester wins; if both request, the one that is not the last-served pointer wins.
  - PRIO_MODE=1: req0 wins whenever it is high.
  - At that same edge: latch the winner's A/B into operand registers, set gnt_winner = 1 and res_id = winner, load counter = ADD_LAT, go to COMPUTE.
- COMPUTE:
  - gnt clears at the first edge after it was set; gnt is high for exactly 1 cycle.
  - Counter decrements each edge.
  - At the edge where the counter reaches 0, capture the adder output into res_sum, set res_valid = 1, go to RESP.
  - res_valid therefore rises ADD_LAT edges after the grant edge.
- RESP:
  - res_valid, res_sum and res_id are held stable until res_ack is sampled high.
  - At that edge: res_valid = 0, last-served pointer = res_id, go to IDLE. res_sum keeps its value.
  - res_ack while res_valid = 0 is ignored.
- Throughput:
  - The earliest next grant is the edge after the ack edge. Minimum op period = ADD_LAT + 2 cycles.
  - req and operands are not sampled outside IDLE; requesters hold req and operands until they see gnt.
  - A requester holding req high after gnt gets another operation.
  - PRIO_MODE=0 with both requesters held high: grants alternate 0,1,0,1.
- Arithmetic (datapath contract):
  - Same signs: magnitude = |A| + |B| (8 bits, no overflow possible); sign = common sign.
  - Different signs: magnitude = larger minus smaller; sign = sign of the operand with the larger magnitude.
  - |A| == |B| with differing signs: magnitude 0, sign = sign of B.
- Operand registers are the only source for the adder; input changes after the grant never affect the result.

Optional Feature:
- Macro: SM_NEG_ZERO_CLAMP_EN.
- Defined: at capture, if res_sum[7:0] == 0 then res_sum[8] is forced to 0. No -0 ever leaves the block.
- Undefined: the captured value is passed unmodified, so -0 (9'h100) is possible per the equal-magnitude rule.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset then req0=1, a0=8'h05, b0=8'h83, ADD_LAT=1 -> gnt0 pulse at grant edge; res_valid 1 edge later; res_sum=9'h002, res_id=0; held until res_ack, then res_valid=0.
- req1 only, a1=8'h7F, b1=8'h7F, then a1=8'h85, b1=8'h85 -> res_sum=9'h0FE, then 9'h10A; res_id=1 both times.
- PRIO_MODE=0, req0 and req1 held high, ack given the cycle after each res_valid -> grant order 0,1,0,1 and res_id alternates; PRIO_MODE=1 same stimulus -> only gnt0 ever pulses.
- a0=8'h05, b0=8'h85 -> res_sum=9'h100 without SM_NEG_ZERO_CLAMP_EN, 9'h000 with it.
- ADD_LAT=3; change a0/b0 on the cycle after gnt0 -> res_valid exactly 3 edges after the grant edge, and the result reflects the latched operands.
- rst_n low for one edge while in COMPUTE -> all outputs 0, busy=0, no res_valid; after release with req0 and req1 both high, requester 0 is granted first.
